issue_scheduler: RTL and testbench

//  Issue controller between DECODE and the two execute pipelines: ALU/mem and multiplier.

---
 rtl/issue_scheduler.sv | 93 +++++++++
 tb/tb_issue_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Issue scheduler: writeback reservation table, hazard detection and
// regfile write-port select for an ALU/mem pipeline and a multiplier.
module issue_scheduler #(
  parameter int REG_ADDR = 5,
  parameter int ALU_LAT  = 3,
  parameter int MUL_LAT  = 6,
  parameter int MUL_II   = 2,
  localparam int CW      = $clog2(MUL_LAT+1),
  localparam int IIW     = (MUL_II > 1) ? $clog2(MUL_II) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                id_use_src1,
  input  logic                id_use_src2,
  input  logic [REG_ADDR-1:0] id_src1,
  input  logic [REG_ADDR-1:0] id_src2,
  input  logic [REG_ADDR-1:0] id_dest,
  input  logic                id_regwrite,
  input  logic                id_is_mult,
  output logic                issue,
  output logic                stall,
  output logic                wb_valid,
  output logic                wb_sel,
  output logic [REG_ADDR-1:0] wb_dest,
  output logic [CW-1:0]       busy_count
);

  typedef struct packed {
    logic                v;
    logic                sel;
    logic [REG_ADDR-1:0] dest;
  } ent_t;

  ent_t           res_q [MUL_LAT];
  ent_t           res_d [MUL_LAT];
  logic [CW-1:0]  busy_q, busy_d;
  logic [IIW-1:0] mul_ii_q, mul_ii_d;
  logic           raw, waw, strc, mulb;

  // Hazard terms against the current table; res[0] retires this cycle and
  // writes the regfile before the read, so it never blocks.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int k = 1; k < MUL_LAT; k++) begin
      if (res_q[k].v) begin
        if (id_use_src1 && (id_src1 == res_q[k].dest)) raw = 1'b1;
        if (id_use_src2 && (id_src2 == res_q[k].dest)) raw = 1'b1;
        if (id_regwrite && (id_dest == res_q[k].dest)) waw = 1'b1;
      end
    end
    // ALU insert lands where res[ALU_LAT] shifts to; mult slot is always free.
    strc  = ~id_is_mult & id_regwrite & res_q[ALU_LAT].v;
    mulb  = id_is_mult & (mul_ii_q != '0);
    issue = id_valid & ~reset & ~(raw | waw | strc | mulb);
    stall = id_valid & ~reset & ~issue;
  end

  // Next table: shift toward writeback, then insert the issuing write.
  always_comb begin
    for (int k = 0; k < MUL_LAT-1; k++) res_d[k] = res_q[k+1];
    res_d[MUL_LAT-1] = '0;
    if (issue && id_regwrite) begin
      if (id_is_mult) res_d[MUL_LAT-1] = '{v: 1'b1, sel: 1'b1, dest: id_dest};
      else            res_d[ALU_LAT-1] = '{v: 1'b1, sel: 1'b0, dest: id_dest};
    end
    busy_d = '0;
    for (int k = 0; k < MUL_LAT; k++) busy_d = busy_d + CW'(res_d[k].v);
    if (issue && id_is_mult)  mul_ii_d = IIW'(MUL_II-1);
    else if (mul_ii_q != '0)  mul_ii_d = mul_ii_q - IIW'(1);
    else                      mul_ii_d = mul_ii_q;
  end

  // State registers; reset drops all in-flight writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MUL_LAT; k++) res_q[k] <= '0;
      busy_q   <= '0;
      mul_ii_q <= '0;
    end else begin
      for (int k = 0; k < MUL_LAT; k++) res_q[k] <= res_d[k];
      busy_q   <= busy_d;
      mul_ii_q <= mul_ii_d;
    end
  end

  assign wb_valid   = res_q[0].v;
  assign wb_sel     = res_q[0].sel;
  assign wb_dest    = res_q[0].dest;
  assign busy_count = busy_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler (ALU_LAT=3, MUL_LAT=6, MUL_II=2).
module tb_issue_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid, id_use_src1, id_use_src2, id_regwrite, id_is_mult;
  logic [4:0] id_src1, id_src2, id_dest;
  logic       issue, stall, wb_valid, wb_sel;
  logic [4:0] wb_dest;
  logic [2:0] busy_count;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scheduler #(.REG_ADDR(5), .ALU_LAT(3), .MUL_LAT(6), .MUL_II(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_is_mult(id_is_mult),
    .issue(issue), .stall(stall), .wb_valid(wb_valid), .wb_sel(wb_sel),
    .wb_dest(wb_dest), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic u1, input logic u2,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic rw, input logic m);
    id_valid = v; id_use_src1 = u1; id_use_src2 = u2;
    id_src1 = s1; id_src2 = s2; id_dest = d; id_regwrite = rw; id_is_mult = m;
    #1;
  endtask

  task automatic idle;
    set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b1; idle; tick; tick; reset = 1'b0; #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    n_checks++;
    if ({issue, stall} !== 2'b00) begin n_fail++; $display("FAIL reset_issue_stall: got %b want 00", {issue, stall}); end
    tick;
    n_checks++;
    if ({wb_valid, wb_sel, wb_dest, busy_count} !== 10'd0) begin n_fail++; $display("FAIL reset_state: got v=%b s=%b d=%0d busy=%0d want all 0", wb_valid, wb_sel, wb_dest, busy_count); end
    do_reset;
  endtask

  task automatic test_alu;
    do_reset;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    n_checks++;
    if ({issue, stall} !== 2'b10) begin n_fail++; $display("FAIL alu_issue: got %b want 10", {issue, stall}); end
    tick; idle;
    n_checks++;
    if ({wb_valid, busy_count} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL alu_t1: got v=%b busy=%0d want v=0 busy=1", wb_valid, busy_count); end
    tick;
    n_checks++;
    if (busy_count !== 3'd1) begin n_fail++; $display("FAIL alu_t2_busy: got %0d want 1", busy_count); end
    tick;
    n_checks++;
    if ({wb_valid, wb_sel, wb_dest, busy_count} !== {1'b1, 1'b0, 5'd3, 3'd1}) begin n_fail++; $display("FAIL alu_wb: got v=%b s=%b d=%0d busy=%0d want 1 0 3 1", wb_valid, wb_sel, wb_dest, busy_count); end
    tick;
    n_checks++;
    if ({wb_valid, busy_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL alu_t4: got v=%b busy=%0d want 0 0", wb_valid, busy_count); end
  endtask

  task automatic test_raw_stall;
    do_reset;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL raw_mult_issue: got %b want 1", issue); end
    tick;
    for (int c = 1; c <= 5; c++) begin
      set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0);
      n_checks++;
      if ({issue, stall} !== 2'b01) begin n_fail++; $display("FAIL raw_stall_t%0d: got %b want 01", c, {issue, stall}); end
      tick;
    end
    set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0);
    n_checks++;
    if ({issue, stall, wb_valid, wb_sel, wb_dest} !== {4'b1011, 5'd5}) begin n_fail++; $display("FAIL raw_release: got i=%b s=%b v=%b sel=%b d=%0d want 1 0 1 1 5", issue, stall, wb_valid, wb_sel, wb_dest); end
    tick; idle;
  endtask

  task automatic test_strc;
    do_reset;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL strc_mult_issue: got %b want 1", issue); end
    tick; idle; tick; tick;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    n_checks++;
    if ({issue, stall} !== 2'b01) begin n_fail++; $display("FAIL strc_stall: got %b want 01", {issue, stall}); end
    tick;
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL strc_issue: got %b want 1", issue); end
    tick; idle; tick;
    n_checks++;
    if ({wb_valid, wb_sel, wb_dest} !== {2'b11, 5'd7}) begin n_fail++; $display("FAIL strc_wb_mult: got v=%b s=%b d=%0d want 1 1 7", wb_valid, wb_sel, wb_dest); end
    tick;
    n_checks++;
    if ({wb_valid, wb_sel, wb_dest} !== {2'b10, 5'd8}) begin n_fail++; $display("FAIL strc_wb_alu: got v=%b s=%b d=%0d want 1 0 8", wb_valid, wb_sel, wb_dest); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1);
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b want 1", issue); end
    tick;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
    n_checks++;
    if ({issue, stall} !== 2'b01) begin n_fail++; $display("FAIL b2b_ii_stall: got %b want 01", {issue, stall}); end
    tick;
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %b want 1", issue); end
    tick; idle;
    n_checks++;
    if (busy_count !== 3'd2) begin n_fail++; $display("FAIL b2b_busy: got %0d want 2", busy_count); end
    tick; tick; tick;
    n_checks++;
    if ({wb_valid, wb_sel, wb_dest} !== {2'b11, 5'd1}) begin n_fail++; $display("FAIL b2b_wb1: got v=%b s=%b d=%0d want 1 1 1", wb_valid, wb_sel, wb_dest); end
    tick;
    n_checks++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b want 0", wb_valid); end
    tick;
    n_checks++;
    if ({wb_valid, wb_sel, wb_dest} !== {2'b11, 5'd2}) begin n_fail++; $display("FAIL b2b_wb2: got v=%b s=%b d=%0d want 1 1 2", wb_valid, wb_sel, wb_dest); end
    tick;
    n_checks++;
    if (busy_count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d want 0", busy_count); end
  endtask

  task automatic test_waw;
    do_reset;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    tick;
    for (int c = 1; c <= 5; c++) begin
      set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd4, 1'b1, 1'b0);
      n_checks++;
      if ({issue, stall} !== 2'b01) begin n_fail++; $display("FAIL waw_stall_t%0d: got %b want 01", c, {issue, stall}); end
      tick;
    end
    set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 5'd4, 1'b1, 1'b0);
    n_checks++;
    if ({issue, wb_valid, wb_sel, wb_dest} !== {3'b111, 5'd4}) begin n_fail++; $display("FAIL waw_release: got i=%b v=%b s=%b d=%0d want 1 1 1 4", issue, wb_valid, wb_sel, wb_dest); end
    tick; idle; tick; tick;
    n_checks++;
    if ({wb_valid, wb_sel, wb_dest} !== {2'b10, 5'd4}) begin n_fail++; $display("FAIL waw_wb_alu: got v=%b s=%b d=%0d want 1 0 4", wb_valid, wb_sel, wb_dest); end
  endtask

  task automatic test_no_write;
    logic seen;
    do_reset;
    set_id(1'b1, 1'b1, 1'b1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL store_issue: got %b want 1", issue); end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick; idle;
      if (wb_valid !== 1'b0 || busy_count !== 3'd0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL store_no_entry: got entry=%b want 0", seen); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    do_reset;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1);
    tick;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
    tick;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
    tick; idle;
    n_checks++;
    if (busy_count !== 3'd3) begin n_fail++; $display("FAIL mid_busy3: got %0d want 3", busy_count); end
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
    reset = 1'b1; #1;
    n_checks++;
    if ({issue, stall, wb_valid, busy_count} !== 6'd0) begin n_fail++; $display("FAIL mid_reset_now: got i=%b s=%b v=%b busy=%0d want 0 0 0 0", issue, stall, wb_valid, busy_count); end
    tick; reset = 1'b0; idle;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (wb_valid !== 1'b0 || busy_count !== 3'd0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got wb_after_reset=%b want 0", seen); end
    // Mult issue, async reset pulse, then a mult must issue at once.
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1);
    tick;
    reset = 1'b1; #1; reset = 1'b0;
    set_id(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
    n_checks++;
    if (issue !== 1'b1) begin n_fail++; $display("FAIL mid_ii_cleared: got %b want 1", issue); end
    tick; idle;
  endtask

  initial begin
    idle;
    test_reset;
    test_alu;
    test_raw_stall;
    test_strc;
    test_back_to_back;
    test_waw;
    test_no_write;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
